queue_reader: RTL
=================

QUEUE_READER -- requirements
Module: queue_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one queue entry and output word.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port q_rdata_i  input  DATA_WIDTH: queue head word; first-word-fall-through, valid whenever q_empty_i is 0.
REQ-005 SHALL have port q_empty_i  input  1: queue empty; the connected queue derives it from registered pointers only.
REQ-006 SHALL have port q_deq_o  output  1: dequeue strobe to queue; pops the head word on the same edge.
REQ-007 SHALL have port flush_i  input  1: discard all buffered words (pipeline squash).
REQ-008 SHALL have port out_valid_o  output  1: out_data_o holds a word.
REQ-009 SHALL have port out_data_o  output  DATA_WIDTH: oldest buffered word.
REQ-010 SHALL have port out_ready_i  input  1: consumer accepts the word this cycle.

Function
REQ-011 SHALL hold a 2-entry in-order buffer; occupancy state ST_EMPTY, ST_ONE, ST_TWO.
REQ-012 SHALL drive q_deq_o = !q_empty_i && !flush_i && state != ST_TWO; no combinational path from out_ready_i to q_deq_o.
REQ-013 SHALL capture q_rdata_i on every edge where q_deq_o is 1; captured word visible on out_data_o next cycle if buffer was empty (1-cycle latency).
REQ-014 SHALL treat transfer as out_valid_o && out_ready_i; transferred word removed at the edge.
REQ-015 SHALL, with simultaneous capture and transfer, keep occupancy unchanged and preserve FIFO order.
REQ-016 SHALL transition: EMPTY->ONE on capture; ONE->TWO on capture without transfer; ONE->EMPTY on transfer without capture; TWO->ONE on transfer; otherwise hold.
REQ-017 SHALL drive out_valid_o = (state != ST_EMPTY), purely registered; out_data_o from a register, never from q_rdata_i directly.
REQ-018 SHALL hold out_data_o stable while out_valid_o && !out_ready_i.
REQ-019 SHALL, on flush_i, set state ST_EMPTY at the edge; a transfer in the flush cycle still completes; no capture occurs that cycle.
REQ-020 SHALL ignore q_rdata_i when q_empty_i is 1; q_empty_i at 1 in ST_EMPTY keeps out_valid_o 0 indefinitely.

Reset
REQ-021 SHALL, while rst_n is 0, force state ST_EMPTY, out_valid_o 0, out_data_o 0, q_deq_o 0, buffer entries 0.
REQ-022 SHALL take reset asynchronously mid-transfer; in-flight words are lost, no dequeue issued.
REQ-023 SHALL resume normal operation on the first rising edge after rst_n returns to 1.

Configuration
REQ-024 SHALL support macro QUEUE_READER_PERF_EN; when defined, add output perf_stall_o (32 bits): count of cycles with out_valid_o && !out_ready_i, reset to 0, wrapping at 2^32, cleared by flush_i.
REQ-025 SHALL, without QUEUE_READER_PERF_EN, omit the perf_stall_o port and counter entirely; all other behaviour identical.

Structure
REQ-026 SHALL place enum queue_reader_state_t (ST_EMPTY, ST_ONE, ST_TWO) in shared package rv32i_types.
REQ-027 SHALL be implemented as one module, no sub-modules; DATA_WIDTH is the only parameter.

Verification
REQ-028 Reset: rst_n 0 with q_empty_i 0 -> q_deq_o 0, out_valid_o 0, out_data_o 0.
REQ-029 Streaming: queue holds 0x11,0x22,0x33, out_ready_i 1 -> q_deq_o 1 for 3 cycles; out_data_o 0x11,0x22,0x33 on consecutive cycles, 1 cycle after each dequeue.
REQ-030 Backpressure: out_ready_i 0, queue holds 0xA,0xB,0xC -> exactly 2 dequeues, q_deq_o 0 afterwards, out_data_o 0xA stable; raise out_ready_i -> 0xA,0xB,0xC in order.
REQ-031 Flush: ST_TWO holding 0x5,0x6, flush_i 1 with out_ready_i 1 -> 0x5 accepted that cycle, q_deq_o 0, next cycle out_valid_o 0.
REQ-032 Empty source: q_empty_i 1 for 10 cycles -> q_deq_o 0, out_valid_o 0 throughout; q_empty_i falls with head 0x77 -> out_data_o 0x77 valid 1 cycle later.
REQ-033 Perf (QUEUE_READER_PERF_EN): 7 stall cycles -> perf_stall_o 7; flush_i -> 0 next cycle.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared type definitions; carries the occupancy encoding used by queue_reader.
package rv32i_types;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } queue_reader_state_t;

endpackage

// File: rtl/queue_reader.sv
// Two-entry in-order skid buffer between a FWFT queue and a ready/valid consumer.
// Optional stall counter port perf_stall_o is built when QUEUE_READER_PERF_EN is defined.
module queue_reader
    import rv32i_types::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] q_rdata_i,
    input  logic                  q_empty_i,
    output logic                  q_deq_o,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i
`ifdef QUEUE_READER_PERF_EN
    ,
    output logic [31:0]           perf_stall_o
`endif
);

    queue_reader_state_t   state_p0;
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] head_p0;
    logic [DATA_WIDTH-1:0] tail_p0;
    logic                  capture;
    logic                  xfer;

    // Dequeue depends only on registered occupancy, so the consumer's ready never reaches the queue.
    assign q_deq_o     = rst_n && !q_empty_i && !flush_i && (state_p0 != ST_TWO);
    assign capture     = q_deq_o;
    assign xfer        = vld_p0 && out_ready_i;
    assign out_valid_o = vld_p0;
    assign out_data_o  = head_p0;

    // Head entry drives the output; tail holds the second word while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= ST_EMPTY;
            vld_p0   <= 1'b0;
            head_p0  <= '0;
            tail_p0  <= '0;
        end else if (flush_i) begin
            state_p0 <= ST_EMPTY;
            vld_p0   <= 1'b0;
        end else begin
            case (state_p0)
                ST_EMPTY: begin
                    if (capture) begin
                        head_p0  <= q_rdata_i;
                        state_p0 <= ST_ONE;
                        vld_p0   <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (capture && xfer) begin
                        head_p0 <= q_rdata_i;
                    end else if (capture) begin
                        tail_p0  <= q_rdata_i;
                        state_p0 <= ST_TWO;
                    end else if (xfer) begin
                        state_p0 <= ST_EMPTY;
                        vld_p0   <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (xfer) begin
                        head_p0  <= tail_p0;
                        state_p0 <= ST_ONE;
                    end
                end
                default: begin
                    state_p0 <= ST_EMPTY;
                    vld_p0   <= 1'b0;
                end
            endcase
        end
    end

`ifdef QUEUE_READER_PERF_EN
    logic [31:0] stall_cnt_p0;

    assign perf_stall_o = stall_cnt_p0;

    // Flush clears the count even when that cycle is itself a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_p0 <= '0;
        end else if (flush_i) begin
            stall_cnt_p0 <= '0;
        end else if (vld_p0 && !out_ready_i) begin
            stall_cnt_p0 <= stall_cnt_p0 + 32'd1;
        end
    end
`endif

endmodule
